control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Produces the one-hot {exec2, exec1, fetch} state vector and the latched 4-bit opcode that the instruction decoder consumes.
- Owns the instruction register and the program-memory fetch handshake.
- Sequences each instruction through FETCH, EXEC1 and, when required, EXEC2; parks in HALT on STP or in PAUSE when single-stepping.
- Sits between program memory and the decoder in the Harvard CPU; also provides a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- OPERAND_W, 4: operand field width; the program word is 4+OPERAND_W bits, opcode in the MSBs.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; leaves HALT or PAUSE toward FETCH.
- step_mode  in  1  when 1, enter PAUSE after every retired instruction.
- step  in  1  level; leaves PAUSE toward FETCH.
- prog_ready  in  1  program memory has valid prog_data this cycle.
- prog_data  in  4+OPERAND_W  program word; [OPERAND_W+3:OPERAND_W] is the opcode.
- prog_rd  out  1  fetch request; high exactly while state==FETCH.
- state  out  3  one-hot: 001 FETCH, 010 EXEC1, 100 EXEC2, 000 HALT/PAUSE.
- inst  out  4  latched opcode.
- operand  out  OPERAND_W  latched operand.
- halted  out  1  high only in HALT.
- paused  out  1  high only in PAUSE.
- illegal  out  1  sticky: an undefined opcode was fetched.
- instr_count  out  CNT_W  retired-instruction count; wraps.

Behaviour:
- Reset: clock and reset are fixed as one clock, synchronous active-high reset; there is no asynchronous path. On rst=1 at an edge: state=FETCH (001), inst=0, operand=0, illegal=0, instr_count=0. Reset wins over every other input, including mid-instruction and in HALT/PAUSE.
- Derived outputs: prog_rd=1, halted=0, paused=0 in FETCH.
- Defined opcodes:
  - LDI 0000, STA 0001, ADD 0010, JMP 0011, STP 0100, LDA 0101, JMS 0110, BBL 0111, LDR 1101, JEQ 1110.
  - Two-cycle set (uses EXEC2): LDA, ADD, LDR. All other opcodes use EXEC1 only.
- FETCH:
  - Holds while prog_ready=0; IR unchanged.
  - When prog_ready=1: at that edge, load inst/operand from prog_data and go to EXEC1.
  - If the loaded opcode is undefined, set illegal=1 (sticky). The instruction still executes as a one-cycle NOP.
- EXEC1:
  - Two-cycle opcode: go to EXEC2.
  - STP: go to HALT and increment the counter; step_mode is ignored.
  - Otherwise retire (see Retire).
- EXEC2: retire.
- Retire: increment instr_count (mod 2^CNT_W). Next state is PAUSE if step_mode=1, else FETCH.
- HALT: state=000, halted=1. run=1 goes to FETCH; step is ignored.
- PAUSE:
  - state=000, paused=1.
  - run=1 or step=1 goes to FETCH.
  - Deasserting step_mode while paused does not by itself resume.
- Both run and step are sampled as levels. A held step with step_mode=1 therefore executes back-to-back, one PAUSE cycle between instructions.
- inst/operand are stable from the cycle after the fetch edge until the next fetch edge, including through HALT/PAUSE.
- Latency with prog_ready tied high: one-cycle instruction = 2 clocks; two-cycle instruction = 3 clocks; STP = 2 clocks into HALT.
- Every prog_ready wait cycle adds one clock in FETCH.
- prog_ready outside FETCH is ignored.

Test Plan:
- Reset then prog_ready=1, program LDI, ADD, STA, STP:
  - state sequence 001,010, 001,010,100, 001,010, 001,010, 000.
  - halted=1; instr_count=4.
  - inst reads 0000, 0010, 0001, 0100 in turn.
- Fetch wait states, LDA with prog_ready low for 3 cycles:
  - state holds 001 with prog_rd=1 for 3 cycles, then 010, 100.
  - inst stays at its previous value until the ready edge.
- step_mode=1 with JMP then LDR:
  - after JMP EXEC1, state=000 and paused=1.
  - step=1 for one cycle gives FETCH; LDR then runs 010,100 and re-pauses; count increments by 1 per instruction.
- Undefined opcode 1000:
  - EXEC1 only, then FETCH; illegal=1 and stays 1 across later instructions; count increments.
  - rst clears illegal to 0.
- rst asserted during EXEC2 of ADD:
  - next cycle state=001, inst=0, instr_count=0; the ADD does not retire.
- HALT, then run pulse:
  - state 000→001, halted drops the same edge.
  - With CNT_W=2 and 4 further retirements from count 3, count wraps 3→0→1→2→3.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: FETCH/EXEC1/EXEC2 sequencer with IR, fetch handshake, HALT/PAUSE, retire counter
// Ports: clk, rst (sync, active-high); run/step/step_mode resume and single-step controls;
// prog_ready/prog_data/prog_rd program-memory fetch handshake; state one-hot {exec2,exec1,fetch};
// inst/operand latched instruction; halted/paused park flags; illegal sticky undefined-opcode flag;
// instr_count wrapping retired-instruction count.
module control_sequencer #(
  parameter int OPERAND_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   prog_ready,
  input  logic [OPERAND_W+3:0]   prog_data,
  output logic                   prog_rd,
  output logic [2:0]             state,
  output logic [3:0]             inst,
  output logic [OPERAND_W-1:0]   operand,
  output logic                   halted,
  output logic                   paused,
  output logic                   illegal,
  output logic [CNT_W-1:0]       instr_count
);
  typedef enum logic [2:0] {S_FETCH, S_EXEC1, S_EXEC2, S_HALT, S_PAUSE} st_t;
  st_t cur, nxt;
  logic [3:0] op_in;
  logic       two_cycle, defined, retire;
  assign op_in     = prog_data[OPERAND_W+3:OPERAND_W];
  assign two_cycle = inst == 4'b0101 || inst == 4'b0010 || inst == 4'b1101;
  assign defined   = !op_in[3] || op_in == 4'b1101 || op_in == 4'b1110;
  // STP bumps the counter on its way to HALT just like a normal retire
  assign retire    = (cur == S_EXEC1 && !two_cycle) || cur == S_EXEC2;
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_FETCH;
      inst        <= '0;
      operand     <= '0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH && prog_ready) begin
        inst    <= op_in;
        operand <= prog_data[OPERAND_W-1:0];
        illegal <= illegal | !defined;
      end
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH: nxt = prog_ready ? S_EXEC1 : S_FETCH;
      S_EXEC1: nxt = two_cycle ? S_EXEC2 : inst == 4'b0100 ? S_HALT : step_mode ? S_PAUSE : S_FETCH;
      S_EXEC2: nxt = step_mode ? S_PAUSE : S_FETCH;
      S_HALT:  nxt = run ? S_FETCH : S_HALT;
      S_PAUSE: nxt = (run || step) ? S_FETCH : S_PAUSE;
      default: nxt = S_FETCH;
    endcase
  end
  always_comb begin
    state   = {cur == S_EXEC2, cur == S_EXEC1, cur == S_FETCH};
    prog_rd = cur == S_FETCH;
    halted  = cur == S_HALT;
    paused  = cur == S_PAUSE;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed plus randomized instruction trace checked against a spec-level model
module tb_control_sequencer;
  logic       clk = 1'b0, rst = 1'b1, run = 1'b0, step_mode = 1'b0, step = 1'b0, prog_ready = 1'b0;
  logic [7:0] prog_data = '0;
  logic       prog_rd, halted, paused, illegal;
  logic [2:0] state;
  logic [3:0] inst, operand;
  logic [15:0] instr_count;
  logic       prog_rd2, halted2, paused2, illegal2;
  logic [2:0] state2;
  logic [3:0] inst2, operand2;
  logic [1:0] instr_count2;
  int checks = 0, errors = 0;
  int e_cnt = 0;
  logic [3:0] e_inst = '0, e_opnd = '0;
  logic       e_ill = 1'b0;

  control_sequencer dut (.clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
    .prog_ready(prog_ready), .prog_data(prog_data), .prog_rd(prog_rd), .state(state), .inst(inst),
    .operand(operand), .halted(halted), .paused(paused), .illegal(illegal), .instr_count(instr_count));
  control_sequencer #(.OPERAND_W(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .run(run),
    .step_mode(step_mode), .step(step), .prog_ready(prog_ready), .prog_data(prog_data),
    .prog_rd(prog_rd2), .state(state2), .inst(inst2), .operand(operand2), .halted(halted2),
    .paused(paused2), .illegal(illegal2), .instr_count(instr_count2));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic is_defined(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1101, 4'b1110};
  endfunction
  function automatic logic is_two(input logic [3:0] op);
    return op inside {4'b0101, 4'b0010, 4'b1101};
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_common(input string tag);
    chk({tag, ":inst"}, {28'd0, inst}, {28'd0, e_inst});
    chk({tag, ":operand"}, {28'd0, operand}, {28'd0, e_opnd});
    chk({tag, ":illegal"}, {31'd0, illegal}, {31'd0, e_ill});
    chk({tag, ":count"}, {16'd0, instr_count}, e_cnt & 32'hFFFF);
    chk({tag, ":count2"}, {30'd0, instr_count2}, e_cnt & 32'h3);
    chk({tag, ":state2"}, {29'd0, state2}, {29'd0, state});
  endtask

  // Expects to start in FETCH; ends in FETCH, PAUSE or HALT as the rules dictate.
  task automatic do_instr(input logic [3:0] op, input logic [3:0] opnd, input int waits, input logic smode);
    step_mode = smode;
    for (int i = 0; i < waits; i++) begin
      prog_ready = 1'b0;
      prog_data  = 8'($urandom);
      tick;
      chk("wait_state", {29'd0, state}, 32'b001);
      chk("wait_prog_rd", {31'd0, prog_rd}, 32'd1);
      chk_common("wait");
    end
    prog_ready = 1'b1;
    prog_data  = {op, opnd};
    tick;
    e_inst = op;
    e_opnd = opnd;
    if (!is_defined(op)) e_ill = 1'b1;
    chk("exec1_state", {29'd0, state}, 32'b010);
    chk("exec1_prog_rd", {31'd0, prog_rd}, 32'd0);
    chk_common("exec1");
    prog_ready = 1'($urandom);
    prog_data  = 8'($urandom);
    if (is_two(op)) begin
      tick;
      chk("exec2_state", {29'd0, state}, 32'b100);
      chk_common("exec2");
    end
    tick;
    e_cnt++;
    prog_ready = 1'b0;
    if (op == 4'b0100) begin
      chk("halt_state", {29'd0, state}, 32'b000);
      chk("halt_flag", {30'd0, halted, paused}, 32'b10);
    end else if (smode) begin
      chk("pause_state", {29'd0, state}, 32'b000);
      chk("pause_flag", {30'd0, halted, paused}, 32'b01);
    end else begin
      chk("retire_state", {29'd0, state}, 32'b001);
      chk("retire_flags", {30'd0, halted, paused}, 32'b00);
    end
    chk_common("retire");
  endtask

  task automatic resume_halt;
    step = 1'b1;
    tick;
    step = 1'b0;
    chk("halt_step_ignored", {29'd0, state}, 32'b000);
    chk("halt_still", {31'd0, halted}, 32'd1);
    run = 1'b1;
    tick;
    run = 1'b0;
    chk("halt_run_state", {29'd0, state}, 32'b001);
    chk("halt_run_flags", {30'd0, halted, paused}, 32'b00);
    chk_common("halt_run");
  endtask

  task automatic resume_pause(input logic use_step);
    step_mode = 1'b0;
    repeat ($urandom_range(1, 2)) begin
      tick;
      chk("pause_hold", {29'd0, state}, 32'b000);
      chk("pause_hold_flag", {31'd0, paused}, 32'd1);
    end
    if (use_step) step = 1'b1; else run = 1'b1;
    tick;
    step = 1'b0;
    run  = 1'b0;
    chk("pause_resume_state", {29'd0, state}, 32'b001);
    chk("pause_resume_flag", {31'd0, paused}, 32'd0);
    chk_common("pause_resume");
  endtask

  initial begin
    logic [3:0] op;
    repeat (2) tick;
    rst = 1'b0;
    chk("reset_state", {29'd0, state}, 32'b001);
    chk("reset_prog_rd", {31'd0, prog_rd}, 32'd1);
    chk("reset_flags", {30'd0, halted, paused}, 32'b00);
    chk_common("reset");
    // LDI, ADD, STA, STP
    do_instr(4'b0000, 4'h3, 0, 1'b0);
    do_instr(4'b0010, 4'h5, 0, 1'b0);
    do_instr(4'b0001, 4'h9, 0, 1'b0);
    do_instr(4'b0100, 4'h0, 0, 1'b0);
    chk("prog_count4", {16'd0, instr_count}, 32'd4);
    resume_halt;
    // LDA with 3 fetch wait cycles
    do_instr(4'b0101, 4'hA, 3, 1'b0);
    // single-step JMP then LDR
    do_instr(4'b0011, 4'h7, 0, 1'b1);
    step = 1'b1;
    tick;
    step = 1'b0;
    chk("step_fetch", {29'd0, state}, 32'b001);
    do_instr(4'b1101, 4'h2, 0, 1'b1);
    resume_pause(1'b0);
    // held step runs back-to-back with one PAUSE cycle between
    step = 1'b1;
    do_instr(4'b0110, 4'h1, 0, 1'b1);
    tick;
    chk("held_step_fetch", {29'd0, state}, 32'b001);
    do_instr(4'b0111, 4'h4, 0, 1'b1);
    tick;
    step = 1'b0;
    chk("held_step_fetch2", {29'd0, state}, 32'b001);
    // undefined opcode, then illegal stays sticky
    do_instr(4'b1000, 4'hF, 1, 1'b0);
    do_instr(4'b1110, 4'h6, 0, 1'b0);
    // STP ignores step_mode
    do_instr(4'b0100, 4'h0, 0, 1'b1);
    resume_halt;
    // reset during EXEC2 of ADD
    do_instr(4'b0000, 4'h1, 0, 1'b0);
    prog_ready = 1'b1;
    prog_data  = 8'h2C;
    tick;
    prog_ready = 1'b0;
    chk("rst_mid_exec1", {29'd0, state}, 32'b010);
    tick;
    chk("rst_mid_exec2", {29'd0, state}, 32'b100);
    rst = 1'b1;
    run = 1'b1;
    step = 1'b1;
    tick;
    rst = 1'b0;
    run = 1'b0;
    step = 1'b0;
    e_cnt = 0; e_inst = '0; e_opnd = '0; e_ill = 1'b0;
    chk("rst_mid_state", {29'd0, state}, 32'b001);
    chk_common("rst_mid");
    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom);
      do_instr(op, 4'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
      if (halted) resume_halt;
      else if (paused) resume_pause(1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
